// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM: one shared edge/center-aligned period counter, CHANNELS duty comparators,
// and a shadow period/duty/mode set that is only applied at a period boundary or while disabled.
module pwm_multi_channel #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [WIDTH-1:0]          period,
    input  logic [CHANNELS*WIDTH-1:0] duty,
    input  logic                      center_mode,
    input  logic                      load,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic                      period_end,
    output logic [WIDTH-1:0]          count
);

    logic                      r_dir_down;
    logic [WIDTH-1:0]          r_period_a;
    logic [CHANNELS*WIDTH-1:0] r_duty_a;
    logic                      r_mode_a;
    logic [WIDTH-1:0]          r_period_p;
    logic [CHANNELS*WIDTH-1:0] r_duty_p;
    logic                      r_mode_p;
    logic                      r_load_pending;

    logic                      w_term;
    logic                      w_apply;
    logic [WIDTH-1:0]          w_next_period;
    logic [CHANNELS*WIDTH-1:0] w_next_duty;
    logic                      w_next_mode;

    // Terminal cycle: the counter returns to 0 on the next edge.
    always_comb begin
        w_term = 1'b0;
        if (!r_mode_a)
            w_term = (count == r_period_a);
        else
            w_term = (r_period_a == '0) ||
                     ((count == WIDTH'(1)) && (r_dir_down || (r_period_a == WIDTH'(1))));
    end

    // A load in the same cycle as the boundary takes priority over the stored pending set.
    assign w_apply       = load | r_load_pending;
    assign w_next_period = load ? period      : r_period_p;
    assign w_next_duty   = load ? duty        : r_duty_p;
    assign w_next_mode   = load ? center_mode : r_mode_p;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count          <= '0;
            r_dir_down     <= 1'b0;
            r_period_a     <= '0;
            r_duty_a       <= '0;
            r_mode_a       <= 1'b0;
            r_period_p     <= '0;
            r_duty_p       <= '0;
            r_mode_p       <= 1'b0;
            r_load_pending <= 1'b0;
            pwm_out        <= '0;
            period_end     <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++)
                pwm_out[i] <= enable & (count < r_duty_a[i*WIDTH +: WIDTH]);
            period_end <= enable & w_term;

            if (!enable || w_term) begin
                count      <= '0;
                r_dir_down <= 1'b0;
                if (w_apply) begin
                    r_period_a     <= w_next_period;
                    r_duty_a       <= w_next_duty;
                    r_mode_a       <= w_next_mode;
                    r_load_pending <= 1'b0;
                end
            end else begin
                if (load) begin
                    r_period_p     <= period;
                    r_duty_p       <= duty;
                    r_mode_p       <= center_mode;
                    r_load_pending <= 1'b1;
                end
                // Center mode turns around at the peak; edge mode reaches P only as terminal.
                if (r_mode_a && (r_dir_down || (count == r_period_a))) begin
                    count      <= count - WIDTH'(1);
                    r_dir_down <= 1'b1;
                end else begin
                    count <= count + WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Bench for pwm_multi_channel: phase-based reference model checked every cycle,
// plus directed scenarios with hand-computed duty/period expectations.
module tb_pwm_multi_channel;

    localparam int W  = 8;
    localparam int CH = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            enable;
    logic [W-1:0]    period;
    logic [CH*W-1:0] duty;
    logic            center_mode;
    logic            load;
    logic [CH-1:0]   pwm_out;
    logic            period_end;
    logic [W-1:0]    count;

    pwm_multi_channel #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clk(clk), .reset(reset), .enable(enable), .period(period), .duty(duty),
        .center_mode(center_mode), .load(load), .pwm_out(pwm_out),
        .period_end(period_end), .count(count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: position within the period (phase), not a counter/direction pair.
    int m_p, m_mode, m_ph;
    int m_duty[CH];
    int p_p, p_mode, p_flag;
    int p_duty[CH];
    int exp_pwm, exp_pe;

    function automatic int m_len();
        if (m_mode == 0) return m_p + 1;
        if (m_p == 0) return 1;
        return 2 * m_p;
    endfunction

    function automatic int m_cnt();
        if (m_mode != 0 && m_ph > m_p) return 2 * m_p - m_ph;
        return m_ph;
    endfunction

    task automatic m_apply(input int use_inputs);
        if (use_inputs != 0) begin
            m_p = int'(period);
            m_mode = int'(center_mode);
            for (int i = 0; i < CH; i++) m_duty[i] = int'(duty[i*W +: W]);
        end else begin
            m_p = p_p;
            m_mode = p_mode;
            for (int i = 0; i < CH; i++) m_duty[i] = p_duty[i];
        end
        p_flag = 0;
    endtask

    task automatic model_step();
        int c, term;
        if (reset) begin
            m_p = 0; m_mode = 0; m_ph = 0; p_p = 0; p_mode = 0; p_flag = 0;
            for (int i = 0; i < CH; i++) begin m_duty[i] = 0; p_duty[i] = 0; end
            exp_pwm = 0; exp_pe = 0;
            return;
        end
        c = m_cnt();
        term = (m_ph == m_len() - 1) ? 1 : 0;
        exp_pwm = 0;
        for (int i = 0; i < CH; i++)
            if (enable && c < m_duty[i]) exp_pwm |= (1 << i);
        exp_pe = (enable && term != 0) ? 1 : 0;
        if (!enable || term != 0) begin
            m_ph = 0;
            if (load) m_apply(1);
            else if (p_flag != 0) m_apply(0);
        end else begin
            m_ph++;
            if (load) begin
                p_p = int'(period);
                p_mode = int'(center_mode);
                for (int i = 0; i < CH; i++) p_duty[i] = int'(duty[i*W +: W]);
                p_flag = 1;
            end
        end
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        chk("model_count", int'(count), m_cnt());
        chk("model_pwm", int'(pwm_out), exp_pwm);
        chk("model_period_end", int'(period_end), exp_pe);
    end

    int meas_hi[CH];
    int meas_pe, meas_max;
    logic [31:0] meas_bits0;

    task automatic measure(input int n);
        for (int i = 0; i < CH; i++) meas_hi[i] = 0;
        meas_pe = 0; meas_max = 0; meas_bits0 = '0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            for (int i = 0; i < CH; i++) if (pwm_out[i]) meas_hi[i]++;
            if (period_end) meas_pe++;
            if (int'(count) > meas_max) meas_max = int'(count);
            if (k < 32) meas_bits0[k] = pwm_out[0];
        end
    endtask

    task automatic do_load(input int p, input logic [CH*W-1:0] d, input logic m);
        period = W'(p); duty = d; center_mode = m; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_pe();
        int n = 0;
        @(negedge clk);
        while (period_end !== 1'b1 && n < 600) begin @(negedge clk); n++; end
        if (n >= 600) chk("timeout_period_end", n, 0);
    endtask

    task automatic wait_count(input int v);
        int n = 0;
        while (int'(count) != v && n < 600) begin @(negedge clk); n++; end
        if (n >= 600) chk("timeout_count", n, 0);
    endtask

    initial begin
        logic [W*8-1:0] seq;
        reset = 1'b1; enable = 1'b0; load = 1'b0;
        period = '0; duty = '0; center_mode = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_count", int'(count), 0);
        chk("reset_pwm", int'(pwm_out), 0);
        chk("reset_period_end", int'(period_end), 0);
        reset = 1'b0;
        @(negedge clk);

        // Edge mode, P=9: ch0=3 ch1=0 ch2=10 ch3=5
        do_load(9, {8'd5, 8'd10, 8'd0, 8'd3}, 1'b0);
        enable = 1'b1;
        repeat (3) @(negedge clk);
        measure(10);
        chk("edge_ch0_high", meas_hi[0], 3);
        chk("edge_ch1_high", meas_hi[1], 0);
        chk("edge_ch2_high", meas_hi[2], 10);
        chk("edge_ch3_high", meas_hi[3], 5);
        chk("edge_period_end", meas_pe, 1);
        chk("edge_max_count", meas_max, 9);

        // Center mode, P=4, ch0=2
        do_load(4, {8'd0, 8'd0, 8'd0, 8'd2}, 1'b1);
        wait_pe();
        for (int k = 0; k < 8; k++) begin
            seq[k*W +: W] = count;
            if (k < 7) @(negedge clk);
        end
        chk("center_seq_lo", int'(seq[31:0]), int'({8'd3, 8'd2, 8'd1, 8'd0}));
        chk("center_seq_hi", int'(seq[63:32]), int'({8'd1, 8'd2, 8'd3, 8'd4}));
        measure(8);
        chk("center_ch0_high", meas_hi[0], 3);
        chk("center_ch0_shape", int'(meas_bits0[7:0]), 8'b0000_0111);
        chk("center_period_end", meas_pe, 1);

        // Shadow timing: load mid-period, then on the terminal cycle
        do_load(9, {4{8'd3}}, 1'b0);
        wait_pe();
        wait_count(4);
        do_load(9, {4{8'd7}}, 1'b0);
        measure(4);
        chk("shadow_no_early", meas_hi[0], 0);
        measure(10);
        chk("shadow_new_duty", meas_hi[0], 7);
        chk("shadow_period_end", meas_pe, 1);
        wait_count(9);
        do_load(9, {4{8'd2}}, 1'b0);
        measure(10);
        chk("shadow_term_load", meas_hi[0], 2);

        // Degenerate periods
        do_load(0, {4{8'd1}}, 1'b0);
        wait_pe();
        repeat (2) @(negedge clk);
        measure(5);
        chk("p0_ch0_high", meas_hi[0], 5);
        chk("p0_period_end", meas_pe, 5);
        chk("p0_max_count", meas_max, 0);
        do_load(255, {4{8'd128}}, 1'b0);
        wait_pe();
        measure(256);
        chk("p255_ch0_high", meas_hi[0], 128);
        chk("p255_period_end", meas_pe, 1);
        chk("p255_max_count", meas_max, 255);

        // Enable low mid-period, load while disabled
        do_load(9, {8'd10, 8'd0, 8'd0, 8'd4}, 1'b0);
        wait_pe();
        wait_count(5);
        enable = 1'b0;
        @(negedge clk);
        chk("dis_count", int'(count), 0);
        chk("dis_pwm", int'(pwm_out), 0);
        do_load(9, {8'd10, 8'd0, 8'd0, 8'd6}, 1'b0);
        enable = 1'b1;
        measure(10);
        chk("reen_ch0_high", meas_hi[0], 6);
        chk("reen_ch3_high", meas_hi[3], 10);

        // Reset mid-period with a pending load
        do_load(3, {4{8'd1}}, 1'b0);
        wait_count(6);
        chk("pre_reset_ch3", int'(pwm_out[3]), 1);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_count", int'(count), 0);
        chk("async_reset_pwm", int'(pwm_out), 0);
        chk("async_reset_period_end", int'(period_end), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        measure(4);
        chk("post_reset_pwm", meas_hi[0] + meas_hi[3], 0);
        chk("post_reset_max_count", meas_max, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
